// File: rtl/mux4x1_rr.sv
// Four-lane valid/ready collector with round-robin arbitration onto one
// registered output lane; each beat is tagged with its source lane.
module mux4x1_rr #(
  parameter int unsigned W     = 1,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       i_valid,
  input  logic [W-1:0]     i_d0,
  input  logic [W-1:0]     i_d1,
  input  logic [W-1:0]     i_d2,
  input  logic [W-1:0]     i_d3,
  output logic [3:0]       i_ready,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [W-1:0]     o_d,
  output logic [1:0]       o_sel,
  output logic [CNT_W-1:0] xfer_cnt
);

  localparam int unsigned LANES = 4;

  logic             en_q, en_d;
  logic [1:0]       ptr_q, ptr_d;
  logic             vld_q, vld_d;
  logic [W-1:0]     dat_q, dat_d;
  logic [1:0]       sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             load_c;
  logic             gnt_vld_c;
  logic [1:0]       gnt_c;
  logic [W-1:0]     gnt_dat_c;

  assign load_c = !vld_q || o_ready;

  // Rotating priority search starting at ptr; gated off for the first edge
  // after reset release and asynchronously while reset is held.
  always_comb begin
    logic [1:0] idx;
    logic       found;
    found = 1'b0;
    gnt_c = ptr_q;
    idx   = ptr_q;
    for (int k = 0; k < LANES; k++) begin
      idx = ptr_q + 2'(k);
      if (!found && i_valid[idx]) begin
        found = 1'b1;
        gnt_c = idx;
      end
    end
    gnt_vld_c = found && load_c && en_q && rst_n;
  end

  always_comb begin
    gnt_dat_c = i_d0;
    case (gnt_c)
      2'd0: gnt_dat_c = i_d0;
      2'd1: gnt_dat_c = i_d1;
      2'd2: gnt_dat_c = i_d2;
      2'd3: gnt_dat_c = i_d3;
      default: gnt_dat_c = i_d0;
    endcase
  end

  assign i_ready = gnt_vld_c ? (4'b0001 << gnt_c) : 4'b0000;

  always_comb begin
    en_d  = 1'b1;
    ptr_d = ptr_q;
    vld_d = vld_q;
    dat_d = dat_q;
    sel_d = sel_q;
    cnt_d = cnt_q;
    if (gnt_vld_c) begin
      vld_d = 1'b1;
      dat_d = gnt_dat_c;
      sel_d = gnt_c;
      ptr_d = gnt_c + 2'd1;
      cnt_d = cnt_q + CNT_W'(1);
    end else if (load_c) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q  <= 1'b0;
      ptr_q <= 2'd0;
      vld_q <= 1'b0;
      dat_q <= '0;
      sel_q <= 2'd0;
      cnt_q <= '0;
    end else begin
      en_q  <= en_d;
      ptr_q <= ptr_d;
      vld_q <= vld_d;
      dat_q <= dat_d;
      sel_q <= sel_d;
      cnt_q <= cnt_d;
    end
  end

  assign o_valid  = vld_q;
  assign o_d      = dat_q;
  assign o_sel    = sel_q;
  assign xfer_cnt = cnt_q;

endmodule

// File: tb/tb_mux4x1_rr.sv
// Directed-vector bench for mux4x1_rr (W=1, CNT_W=4 to exercise counter wrap).
module tb_mux4x1_rr;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] i_valid;
  logic [3:0] d;
  logic [3:0] i_ready;
  logic       o_valid;
  logic       o_ready;
  logic [0:0] o_d;
  logic [1:0] o_sel;
  logic [3:0] xfer_cnt;

  int n_run  = 0;
  int n_fail = 0;

  mux4x1_rr #(.W(1), .CNT_W(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_valid  (i_valid),
    .i_d0     (d[0]),
    .i_d1     (d[1]),
    .i_d2     (d[2]),
    .i_d3     (d[3]),
    .i_ready  (i_ready),
    .o_valid  (o_valid),
    .o_ready  (o_ready),
    .o_d      (o_d),
    .o_sel    (o_sel),
    .xfer_cnt (xfer_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] vld;
    logic       ordy;
    logic [3:0] exp_rdy;
    logic       exp_ov;
    logic [1:0] exp_sel;
    logic       exp_d;
    logic [3:0] exp_cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic [3:0] vld, logic ordy, logic [3:0] rdy,
                              logic ov, logic [1:0] sel, logic dd, logic [3:0] cnt);
    vec_t v;
    v.vld = vld; v.ordy = ordy; v.exp_rdy = rdy;
    v.exp_ov = ov; v.exp_sel = sel; v.exp_d = dd; v.exp_cnt = cnt;
    return v;
  endfunction

  task automatic chk(string name, int act, int exp);
    n_run++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d @%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_out(string tag, logic ov, logic [1:0] sel, logic dd, logic [3:0] cnt);
    chk({tag, ".o_valid"},  int'(o_valid),  int'(ov));
    chk({tag, ".o_sel"},    int'(o_sel),    int'(sel));
    chk({tag, ".o_d"},      int'(o_d),      int'(dd));
    chk({tag, ".xfer_cnt"}, int'(xfer_cnt), int'(cnt));
  endtask

  initial begin
    // Lane data i_d0..3 = 1,0,1,1
    d = 4'b1101;
    // Round robin, all lanes valid, counting through 8
    tbl.push_back(mk(4'hF, 1, 4'b0001, 1, 2'd0, 1, 4'd1));
    tbl.push_back(mk(4'hF, 1, 4'b0010, 1, 2'd1, 0, 4'd2));
    tbl.push_back(mk(4'hF, 1, 4'b0100, 1, 2'd2, 1, 4'd3));
    tbl.push_back(mk(4'hF, 1, 4'b1000, 1, 2'd3, 1, 4'd4));
    tbl.push_back(mk(4'hF, 1, 4'b0001, 1, 2'd0, 1, 4'd5));
    tbl.push_back(mk(4'hF, 1, 4'b0010, 1, 2'd1, 0, 4'd6));
    tbl.push_back(mk(4'hF, 1, 4'b0100, 1, 2'd2, 1, 4'd7));
    tbl.push_back(mk(4'hF, 1, 4'b1000, 1, 2'd3, 1, 4'd8));
    // Lane 2 alone: pointer sits at 3 yet lane 2 keeps winning
    tbl.push_back(mk(4'b0100, 1, 4'b0100, 1, 2'd2, 1, 4'd9));
    tbl.push_back(mk(4'b0100, 1, 4'b0100, 1, 2'd2, 1, 4'd10));
    tbl.push_back(mk(4'b0100, 1, 4'b0100, 1, 2'd2, 1, 4'd11));
    // No request: o_valid drops, rest holds
    tbl.push_back(mk(4'b0000, 1, 4'b0000, 0, 2'd2, 1, 4'd11));
    // Lane 1 beat, then backpressure for 3 cycles
    tbl.push_back(mk(4'b0010, 1, 4'b0010, 1, 2'd1, 0, 4'd12));
    tbl.push_back(mk(4'hF, 0, 4'b0000, 1, 2'd1, 0, 4'd12));
    tbl.push_back(mk(4'hF, 0, 4'b0000, 1, 2'd1, 0, 4'd12));
    tbl.push_back(mk(4'hF, 0, 4'b0000, 1, 2'd1, 0, 4'd12));
    // Release: lane 2 next, then continuous traffic through counter wrap
    tbl.push_back(mk(4'hF, 1, 4'b0100, 1, 2'd2, 1, 4'd13));
    tbl.push_back(mk(4'hF, 1, 4'b1000, 1, 2'd3, 1, 4'd14));
    tbl.push_back(mk(4'hF, 1, 4'b0001, 1, 2'd0, 1, 4'd15));
    tbl.push_back(mk(4'hF, 1, 4'b0010, 1, 2'd1, 0, 4'd0));
    tbl.push_back(mk(4'hF, 1, 4'b0100, 1, 2'd2, 1, 4'd1));
    tbl.push_back(mk(4'hF, 1, 4'b1000, 1, 2'd3, 1, 4'd2));

    // Reset with every lane requesting
    rst_n = 1'b0; i_valid = 4'hF; o_ready = 1'b1;
    #12;
    chk("rst.i_ready", int'(i_ready), 0);
    chk_out("rst", 0, 2'd0, 0, 4'd0);
    rst_n = 1'b1;
    #1;
    chk("rel.i_ready", int'(i_ready), 0);
    @(posedge clk); #1;
    chk("first.i_ready", int'(i_ready), 1);
    chk_out("first", 0, 2'd0, 0, 4'd0);

    foreach (tbl[i]) begin
      string tag;
      tag = $sformatf("v%0d", i);
      i_valid = tbl[i].vld;
      o_ready = tbl[i].ordy;
      #1;
      chk({tag, ".i_ready"}, int'(i_ready), int'(tbl[i].exp_rdy));
      @(posedge clk); #1;
      chk_out(tag, tbl[i].exp_ov, tbl[i].exp_sel, tbl[i].exp_d, tbl[i].exp_cnt);
    end

    // Reset mid-beat while o_valid=1, o_sel=11
    o_ready = 1'b0; i_valid = 4'hF;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid.i_ready", int'(i_ready), 0);
    chk_out("mid", 0, 2'd0, 0, 4'd0);
    o_ready = 1'b1;
    @(posedge clk); #1;
    chk("midhold.i_ready", int'(i_ready), 0);
    chk_out("midhold", 0, 2'd0, 0, 4'd0);
    rst_n = 1'b1;
    #1;
    chk("rel2.i_ready", int'(i_ready), 0);
    @(posedge clk); #1;
    chk("rel2first.i_ready", int'(i_ready), 1);
    chk_out("rel2first", 0, 2'd0, 0, 4'd0);
    @(posedge clk); #1;
    chk_out("rel2beat", 1, 2'd0, 1, 4'd1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/mux4x1_rr.md
Name: mux4x1_rr

Overview:
- Sequential 4-to-1 collector; the opposite direction of the 1x4 demux lane fan-out.
- Merges four valid/ready input lanes onto one registered output lane.
- Uses round-robin arbitration and tags each output beat with its source lane in demux select encoding (a,b).
- Sits upstream of a demux1X4 so that lane traffic can be split again losslessly.

Parameters:
- W, 1, data width per lane.
- CNT_W, 16, width of the transfer counter.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- i_valid  input  4  per-lane valid; bit n = lane in
- i_d0  input  W  lane i0 data
- i_d1  input  W  lane i1 data
- i_d2  input  W  lane i2 data
- i_d3  input  W  lane i3 data
- i_ready  output  4  per-lane ready, one-hot or zero
- o_valid  output  1  output beat valid
- o_ready  input  1  downstream ready
- o_d  output  W  output data
- o_sel  output  2  source lane; o_sel[1]=a, o_sel[0]=b; 00=i0, 01=i1, 10=i2, 11=i3
- xfer_cnt  output  CNT_W  count of accepted input beats

Behaviour:
- Clocking and reset:
  - One clock, clk.
  - Reset is asynchronous and active-low on rst_n.
  - During reset and on the first edge after release: o_valid=0, o_d=0, o_sel=00, xfer_cnt=0, round-robin pointer ptr=0, i_ready=0000.
- Load condition: load = !o_valid || o_ready.
- Grant logic:
  - Grant is combinational.
  - When load=1, search i_valid in order ptr, ptr+1, ptr+2, ptr+3 (mod 4); the first set bit wins.
  - i_ready has exactly one bit set: the granted lane.
  - i_ready=0000 when load=0 or i_valid=0000.
- On a clock edge with a grant g:
  - o_d <= i_dg, o_sel <= g, o_valid <= 1.
  - ptr <= (g+1) mod 4.
  - xfer_cnt <= xfer_cnt+1, wrapping from 2^CNT_W-1 to 0.
- On a clock edge with load=1 and no request:
  - o_valid <= 0.
  - o_d, o_sel, ptr and xfer_cnt hold.
- Backpressure: when o_valid=1 and o_ready=0, o_d and o_sel hold stable, i_ready=0000, and ptr holds.
- Latency: one cycle from the input handshake (i_valid[g] && i_ready[g]) to o_valid; throughput is one beat per cycle while o_ready=1.
- Simultaneous drain and fill: o_valid && o_ready with a pending request loads the next beat the same edge; there are no bubbles.
- Fairness: any lane held valid is granted within 4 output beats.
- Input lanes must hold i_dn stable while i_valid[n]=1 and i_ready[n]=0; the block does not check this.
- Reset mid-operation: an in-flight output beat is discarded, i_ready drops immediately (combinational from reset), and the pointer returns to 0.
- Width rule: xfer_cnt counts handshakes only, not output beats dropped by reset.

Test Plan:
- Reset with all i_valid=1111 and o_ready=1 -> i_ready=0000, o_valid=0 while rst_n=0. First edge after release grants i0 (i_ready=0001); next edge o_valid=1, o_sel=00.
- W=1, i_valid=1111, data i_d0..3=1,0,1,1, o_ready=1 for 8 cycles -> o_sel sequence 00,01,10,11,00,01,10,11 with o_d 1,0,1,1 repeating; xfer_cnt=8.
- Only i_valid[2]=1 with i_d2=1 -> every cycle o_sel=10, o_d=1; ptr stays at 3 and the grant still returns to lane 2.
- o_valid=1, o_sel=01, o_ready=0 held 3 cycles with all lanes valid -> o_d and o_sel unchanged, i_ready=0000. Raise o_ready -> lane 2 is granted the same cycle, and o_sel=10 on the next edge.
- CNT_W=4, continuous traffic for 17 beats -> xfer_cnt passes 15 to 0 and reads 1 after beat 17.
- Assert rst_n=0 while o_valid=1 and o_sel=11 -> o_valid=0, o_sel=00, xfer_cnt=0 asynchronously, with no handshake on the reset cycle.
